exposure_timer: RTL and testbench
=================================

EXPOSURE_TIMER -- requirements
Module: exposure_timer

Interface
REQ-001 Parameter WIDTH, default 5: width of init and remaining count.
REQ-002 Parameter PRE_W, default 4: width of prescale input and internal prescale counter.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: begin exposure; latches init, prescale and reload.
REQ-006 Port enable, input, 1: count qualifier; low pauses the exposure.
REQ-007 Port abort, input, 1: terminate exposure without signalling done.
REQ-008 Port init, input, WIDTH: exposure length in ticks.
REQ-009 Port prescale, input, PRE_W: one tick every prescale+1 enabled cycles.
REQ-010 Port reload, input, 1: auto-reload (continuous) mode select.
REQ-011 Port busy, output, 1: high in state EXPOSE.
REQ-012 Port exposure_done, output, 1: level, high in state DONE.
REQ-013 Port done_pulse, output, 1: one-cycle strobe per completed exposure period.
REQ-014 Port remaining, output, WIDTH: current tick count.

Function
REQ-015 States: IDLE, EXPOSE, DONE; all outputs registered or decoded from registered state only.
REQ-016 IDLE or DONE with start=1: count<=init, pre_cnt<=0, latch prescale/reload, state<=EXPOSE.
REQ-017 start=1 while in EXPOSE is ignored; no restart, no register change.
REQ-018 EXPOSE, enable=1: if pre_cnt==prescale_latched then pre_cnt<=0 and count decrements, else pre_cnt increments.
REQ-019 EXPOSE, enable=0: count and pre_cnt hold; state holds.
REQ-020 Decrement from 1 to 0 with reload_latched=0: state<=DONE on the same edge, count<=0.
REQ-021 Decrement from 1 to 0 with reload_latched=1: count<=init_latched, stay in EXPOSE.
REQ-022 done_pulse is high for exactly the cycle following each edge on which count reaches 0 (REQ-020 or REQ-021).
REQ-023 Timing: with enable held high, exposure_done rises exactly init*(prescale+1) cycles after the edge sampling start.
REQ-024 start with init==0: state<=DONE on the following edge, with one done_pulse; reload ignored.
REQ-025 DONE holds until start, abort or reset; exposure_done stays high throughout.
REQ-026 abort=1 in any state: state<=IDLE, count<=0, pre_cnt<=0, no done_pulse; abort has priority over start and over count completion on the same edge.
REQ-027 Arithmetic: count never wraps below 0; pre_cnt never exceeds prescale_latched.

Reset
REQ-028 reset has priority over every input, takes effect on the sampling edge, and is honoured mid-exposure.
REQ-029 Reset values: state IDLE, count 0, pre_cnt 0, busy 0, exposure_done 0, done_pulse 0, remaining 0, latched registers 0.

Structure
REQ-030 Package exposure_timer_pkg holds the state enum and default WIDTH/PRE_W constants.
REQ-031 One sub-module, timer_prescaler (parameter PRE_W; inputs clk, reset, clear, enable, prescale; output tick), produces the decrement strobe.

Verification
REQ-032 init=10, prescale=0, reload=0, enable high, start 1 cycle -> busy for 10 cycles, exposure_done high at cycle 10, one done_pulse, remaining 0.
REQ-033 init=3, prescale=2, enable high -> exposure_done at cycle 9; remaining steps 3,2,1,0 every 3 cycles.
REQ-034 init=4, prescale=0, enable low for cycles 2-4 -> done delayed by 3 cycles to cycle 7; remaining frozen while paused.
REQ-035 init=2, reload=1, 8 cycles -> done_pulse at cycles 2,4,6,8; exposure_done never high; abort -> IDLE, no further pulse.
REQ-036 abort and start asserted together mid-exposure -> IDLE; reset during EXPOSE at remaining=5 -> all outputs 0 next cycle.
REQ-037 start with init=0 -> DONE next cycle with single done_pulse; start asserted in DONE restarts a new exposure.

Source files
------------

// File: rtl/exposure_timer_pkg.sv
// Shared types and default sizing for the exposure timer.
//   state_t   : controller state encoding (IDLE, EXPOSE, DONE)
//   DEF_WIDTH : default width of the exposure tick count
//   DEF_PRE_W : default width of the prescale value / counter
package exposure_timer_pkg;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPOSE = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/timer_prescaler.sv
// Divides enabled cycles down to one tick every prescale+1 enabled cycles.
//   clk, reset : clock, synchronous active-high reset
//   clear      : forces the internal counter back to 0 (priority over enable)
//   enable     : count qualifier; low freezes the counter
//   prescale   : terminal count, held stable by the owner while counting
//   tick       : high in the enabled cycle where the counter sits at prescale
module timer_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);
  logic [PRE_W-1:0] pre_cnt;

  assign tick = enable && !clear && (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (reset || clear)
      pre_cnt <= '0;
    else if (enable)
      pre_cnt <= (pre_cnt == prescale) ? '0 : pre_cnt + 1'b1;
  end
endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: counts init ticks (each prescale+1 enabled cycles) and
// reports completion; optional auto-reload runs it as a periodic timer.
//   clk, reset    : clock, synchronous active-high reset
//   start         : launch from IDLE/DONE, latching init/prescale/reload
//   enable        : pause when low
//   abort         : return to IDLE without completing (beats start/completion)
//   init          : exposure length in ticks
//   prescale      : tick divider (prescale+1 cycles per tick)
//   reload        : continuous mode, reload init on each completion
//   busy          : state is EXPOSE
//   exposure_done : state is DONE
//   done_pulse    : one-cycle strobe after each completed period
//   remaining     : current tick count
module exposure_timer
  import exposure_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             abort,
  input  logic [WIDTH-1:0] init,
  input  logic [PRE_W-1:0] prescale,
  input  logic             reload,
  output logic             busy,
  output logic             exposure_done,
  output logic             done_pulse,
  output logic [WIDTH-1:0] remaining
);
  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] init_l;
  logic [PRE_W-1:0] pre_l;
  logic             reload_l;
  logic             tick;

  // The prescaler is held cleared outside EXPOSE so every exposure starts
  // with a fresh divider phase; pausing only drops its enable.
  timer_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk     (clk),
    .reset   (reset),
    .clear   (abort || (state != EXPOSE)),
    .enable  (enable && (state == EXPOSE)),
    .prescale(pre_l),
    .tick    (tick)
  );

  assign busy          = (state == EXPOSE);
  assign exposure_done = (state == DONE);
  assign remaining     = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      init_l     <= '0;
      pre_l      <= '0;
      reload_l   <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              init_l   <= init;
              pre_l    <= prescale;
              reload_l <= reload;
              count    <= init;
              // A zero-length exposure completes immediately; reload is moot.
              if (init == '0) begin
                state      <= DONE;
                done_pulse <= 1'b1;
              end else begin
                state <= EXPOSE;
              end
            end
          end
          EXPOSE: begin
            if (tick && (count != '0)) begin
              if (count == WIDTH'(1)) begin
                done_pulse <= 1'b1;
                if (reload_l) begin
                  count <= init_l;
                end else begin
                  count <= '0;
                  state <= DONE;
                end
              end else begin
                count <= count - 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_exposure_timer.sv
module tb_exposure_timer;
  logic       clk;
  logic       reset, start, enable, abort, reload;
  logic [4:0] init;
  logic [3:0] prescale;
  logic       busy, exposure_done, done_pulse;
  logic [4:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst, st, en, ab;
    logic [4:0] ini;
    logic [3:0] pre;
    logic       rl;
    logic       busy, done, pls;
    logic [4:0] rem;
  } vec_t;

  vec_t tbl[$];

  exposure_timer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .enable       (enable),
    .abort        (abort),
    .init         (init),
    .prescale     (prescale),
    .reload       (reload),
    .busy         (busy),
    .exposure_done(exposure_done),
    .done_pulse   (done_pulse),
    .remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, st, en, ab, input logic [4:0] ini,
                     input logic [3:0] pre, input logic rl,
                     input logic b, d, p, input logic [4:0] r);
    vec_t v;
    v.rst = rst; v.st = st; v.en = en; v.ab = ab; v.ini = ini; v.pre = pre;
    v.rl = rl; v.busy = b; v.done = d; v.pls = p; v.rem = r;
    tbl.push_back(v);
  endtask

  // Drive inputs, then sample outputs 1 time unit after the next rising edge.
  task automatic step(input logic rst, st, en, ab, input logic [4:0] ini,
                      input logic [3:0] pre, input logic rl);
    reset = rst; start = st; enable = en; abort = ab;
    init = ini; prescale = pre; reload = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; enable = 1'b0; abort = 1'b0;
    init = '0; prescale = '0; reload = 1'b0;

    // reset state and idle with no start
    add(1,0,0,0, 0,0,0, 0,0,0,0);
    add(1,1,1,0, 9,0,0, 0,0,0,0);
    add(0,0,1,0, 0,0,0, 0,0,0,0);
    // init=10 prescale=0; a start mid-exposure is ignored
    add(0,1,1,0, 10,0,0, 1,0,0,10);
    for (int k = 1; k <= 9; k++)
      add(0, (k == 5), 1, 0, (k == 5) ? 5'd3 : 5'd10, 0, 0, 1, 0, 0, 5'(10 - k));
    add(0,0,1,0, 10,0,0, 0,1,1,0);
    add(0,0,1,0, 10,0,0, 0,1,0,0);
    add(0,0,0,0, 10,0,0, 0,1,0,0);
    // restart from DONE: init=3 prescale=2 -> steps every 3 cycles, done at 9
    add(0,1,1,0, 3,2,0, 1,0,0,3);
    for (int k = 1; k <= 8; k++)
      add(0,0,1,0, 3,2,0, 1,0,0, 5'(3 - k / 3));
    add(0,0,1,0, 3,2,0, 0,1,1,0);
    add(0,0,1,0, 3,2,0, 0,1,0,0);
    // init=4, enable low for cycles 2-4 -> done at cycle 7
    add(0,1,1,0, 4,0,0, 1,0,0,4);
    add(0,0,1,0, 4,0,0, 1,0,0,3);
    for (int k = 2; k <= 4; k++)
      add(0,0,0,0, 4,0,0, 1,0,0,3);
    add(0,0,1,0, 4,0,0, 1,0,0,2);
    add(0,0,1,0, 4,0,0, 1,0,0,1);
    add(0,0,1,0, 4,0,0, 0,1,1,0);
    // abort out of DONE
    add(0,0,1,1, 4,0,0, 0,0,0,0);
    // reload mode init=2: pulses every 2 cycles, never DONE, then abort
    add(0,1,1,0, 2,0,1, 1,0,0,2);
    for (int k = 1; k <= 8; k++)
      add(0,0,1,0, 2,0,1, 1,0, (k % 2 == 0), (k % 2 == 0) ? 5'd2 : 5'd1);
    add(0,0,1,1, 2,0,1, 0,0,0,0);
    add(0,0,1,0, 2,0,1, 0,0,0,0);
    // abort + start together mid-exposure
    add(0,1,1,0, 8,0,0, 1,0,0,8);
    add(0,0,1,0, 8,0,0, 1,0,0,7);
    add(0,0,1,0, 8,0,0, 1,0,0,6);
    add(0,1,1,1, 4,0,0, 0,0,0,0);
    add(0,0,1,0, 4,0,0, 0,0,0,0);
    // reset mid-exposure at remaining=5
    add(0,1,1,0, 7,0,0, 1,0,0,7);
    add(0,0,1,0, 7,0,0, 1,0,0,6);
    add(0,0,1,0, 7,0,0, 1,0,0,5);
    add(1,1,1,0, 7,0,0, 0,0,0,0);
    add(0,0,1,0, 7,0,0, 0,0,0,0);
    // abort beats completion on the same edge
    add(0,1,1,0, 1,0,0, 1,0,0,1);
    add(0,0,1,1, 1,0,0, 0,0,0,0);
    add(0,0,1,0, 1,0,0, 0,0,0,0);
    // init=0 -> DONE with one pulse (reload ignored), then restart from DONE
    add(0,1,1,0, 0,0,1, 0,1,1,0);
    add(0,0,1,0, 0,0,1, 0,1,0,0);
    add(0,1,1,0, 2,0,0, 1,0,0,2);
    add(0,0,1,0, 2,0,0, 1,0,0,1);
    add(0,0,1,0, 2,0,0, 0,1,1,0);
    add(0,0,1,0, 2,0,0, 0,1,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].en, tbl[i].ab,
           tbl[i].ini, tbl[i].pre, tbl[i].rl);
      n_cmp++;
      if (busy !== tbl[i].busy || exposure_done !== tbl[i].done ||
          done_pulse !== tbl[i].pls || remaining !== tbl[i].rem) begin
        n_bad++;
        $display("FAIL vec%0d: got busy=%b done=%b pulse=%b rem=%0d, expected busy=%b done=%b pulse=%b rem=%0d",
                 i, busy, exposure_done, done_pulse, remaining,
                 tbl[i].busy, tbl[i].done, tbl[i].pls, tbl[i].rem);
      end
    end

    // init=5 prescale=3: done exactly 20 cycles after the start edge
    step(0,1,1,0, 5,3,0);
    n = 0;
    while (!exposure_done && n < 200) begin
      step(0,0,1,0, 5,3,0);
      n++;
    end
    check_int("latency_5x4", n, 20);
    check_int("latency_pulse", int'(done_pulse), 1);

    // init=2 prescale=2 with a mid-tick pause; prescale input changed after
    // start must not matter, and the divider phase must survive the pause
    step(0,1,1,0, 2,2,0);
    step(0,0,1,0, 2,0,0);
    check_int("pause_rem_a", int'(remaining), 2);
    for (int k = 0; k < 5; k++) step(0,0,0,0, 2,0,0);
    check_int("pause_rem_b", int'(remaining), 2);
    n = 0;
    while (!exposure_done && n < 200) begin
      step(0,0,1,0, 2,0,0);
      n++;
    end
    check_int("pause_resume_cycles", n, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
